// File: rtl/irq_controller_if.sv
// Bus bundle between irq_controller and the CPU control path / interrupt sources.
// The slave modport is the controller side; the master modport is the environment side.
interface irq_controller_if #(
    parameter int NUM_SOURCES = 4
) ();
    localparam int ID_W = $clog2(NUM_SOURCES);

    logic [NUM_SOURCES-1:0] irq_lines;
    logic                   mask_write;
    logic [NUM_SOURCES-1:0] mask_data;
    logic                   reset_irq;
    logic                   eoi;
    logic                   irq;
    logic [15:0]            irq_vector;
    logic [ID_W-1:0]        irq_id;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] mask;
    logic                   in_service;

    modport slave (
        input  irq_lines, mask_write, mask_data, reset_irq, eoi,
        output irq, irq_vector, irq_id, pending, mask, in_service
    );

    modport master (
        output irq_lines, mask_write, mask_data, reset_irq, eoi,
        input  irq, irq_vector, irq_id, pending, mask, in_service
    );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority edge-triggered interrupt controller with reset_irq/eoi handshake.
// Optional IRQC_SYNC_EN: 2-flop synchroniser on each line ahead of edge detection.
module irq_controller #(
    parameter int                     NUM_SOURCES   = 4,
    parameter logic [15:0]            VECTOR_BASE   = 16'hFF00,
    parameter logic [15:0]            VECTOR_STRIDE = 16'h0010,
    parameter logic [NUM_SOURCES-1:0] MASK_RESET    = '1
) (
    input logic             clock,
    input logic             reset,
    irq_controller_if.slave bus
);
    localparam int ID_W = $clog2(NUM_SOURCES);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

    state_t                 state, state_next;
    logic [NUM_SOURCES-1:0] pending, pending_next;
    logic [NUM_SOURCES-1:0] mask_q, mask_next;
    logic [NUM_SOURCES-1:0] prev, seen, rise, eligible, clr;
    logic [ID_W-1:0]        irq_id, irq_id_next, sel;
    logic [15:0]            vector, vector_next;
    logic                   irq_q, irq_next, svc_q, svc_next, found;

`ifdef IRQC_SYNC_EN
    logic [NUM_SOURCES-1:0] sync1, sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.irq_lines;
            sync2 <= sync1;
        end
    end

    assign seen = sync2;
`else
    assign seen = bus.irq_lines;
`endif

    // Ones at reset so a line already high produces no event.
    always_ff @(posedge clock) begin
        if (reset) prev <= '1;
        else       prev <= seen;
    end

    assign rise     = seen & ~prev;
    assign eligible = pending & mask_q;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (eligible[i] && !found) begin
                found = 1'b1;
                sel   = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending | rise;
        irq_id_next  = irq_id;
        vector_next  = vector;
        irq_next     = 1'b0;
        svc_next     = 1'b0;
        clr          = '0;
        clr[irq_id]  = 1'b1;
        mask_next    = bus.mask_write ? bus.mask_data : mask_q;
        case (state)
            S_IDLE: begin
                if (found) begin
                    irq_id_next = sel;
                    vector_next = VECTOR_BASE + 16'(sel) * VECTOR_STRIDE;
                    irq_next    = 1'b1;
                    state_next  = S_ASSERT;
                end
            end
            S_ASSERT: begin
                irq_next = 1'b1;
                if (bus.reset_irq) begin
                    // A fresh edge on the acknowledged line re-sets its bit.
                    pending_next = (pending & ~clr) | rise;
                    irq_next     = 1'b0;
                    svc_next     = 1'b1;
                    state_next   = S_SERVICE;
                end
            end
            S_SERVICE: begin
                svc_next = 1'b1;
                if (bus.eoi) begin
                    svc_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            pending <= '0;
            mask_q  <= MASK_RESET;
            irq_id  <= '0;
            vector  <= VECTOR_BASE;
            irq_q   <= 1'b0;
            svc_q   <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            mask_q  <= mask_next;
            irq_id  <= irq_id_next;
            vector  <= vector_next;
            irq_q   <= irq_next;
            svc_q   <= svc_next;
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_vector = vector;
    assign bus.irq_id     = irq_id;
    assign bus.pending    = pending;
    assign bus.mask       = mask_q;
    assign bus.in_service = svc_q;
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random stimulus,
// all outputs compared every cycle against a behavioural model.
module tb_irq_controller;
    localparam int N = 4;
`ifdef IRQC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clock = 1'b0;
    logic reset;

    irq_controller_if #(.NUM_SOURCES(N)) bus ();

    irq_controller #(
        .NUM_SOURCES  (N),
        .VECTOR_BASE  (16'hFF00),
        .VECTOR_STRIDE(16'h0010),
        .MASK_RESET   (4'b1111)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] m_pending, m_mask, m_prev;
    logic [N-1:0] m_dly [0:2];
    bit           m_irq, m_svc;
    int           m_id;
    logic [15:0]  m_vec;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] seen, rise, elig;
        int pick;
        if (reset) begin
            m_pending = '0;
            m_mask    = '1;
            m_prev    = '1;
            for (int j = 0; j < 3; j++) m_dly[j] = '1;
            m_irq = 0;
            m_svc = 0;
            m_id  = 0;
            m_vec = 16'hFF00;
        end else begin
            for (int j = LAT; j > 0; j--) m_dly[j] = m_dly[j-1];
            m_dly[0] = bus.irq_lines;
            seen   = m_dly[LAT];
            rise   = seen & ~m_prev;
            m_prev = seen;
            elig   = m_pending & m_mask;
            pick   = -1;
            for (int i = 0; i < N; i++) if (elig[i] && pick < 0) pick = i;
            if (m_svc) begin
                if (bus.eoi) m_svc = 0;
            end else if (m_irq) begin
                if (bus.reset_irq) begin
                    m_pending[m_id] = 1'b0;
                    m_irq = 0;
                    m_svc = 1;
                end
            end else if (pick >= 0) begin
                m_id  = pick;
                m_vec = 16'(32'hFF00 + 32'(pick) * 32'h10);
                m_irq = 1;
            end
            m_pending = m_pending | rise;
            if (bus.mask_write) m_mask = bus.mask_data;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_eq("irq",        32'(bus.irq),        32'(m_irq));
        check_eq("in_service", 32'(bus.in_service), 32'(m_svc));
        check_eq("pending",    32'(bus.pending),    32'(m_pending));
        check_eq("mask",       32'(bus.mask),       32'(m_mask));
        check_eq("irq_id",     32'(bus.irq_id),     32'(m_id));
        check_eq("irq_vector", 32'(bus.irq_vector), 32'(m_vec));
    endtask

    task automatic pulse_ack();
        bus.reset_irq = 1'b1;
        tick();
        bus.reset_irq = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.irq_lines  = 4'b0010;
        bus.mask_write = 1'b0;
        bus.mask_data  = '0;
        bus.reset_irq  = 1'b0;
        bus.eoi        = 1'b0;
        repeat (3) tick();
        check_eq("reset_vector", 32'(bus.irq_vector), 32'h0000_FF00);
        reset = 1'b0;
        repeat (4) tick();
        check_eq("held_line_no_pending", 32'(bus.pending), 32'h0);
        bus.irq_lines = '0;
        repeat (4) tick();

        // Single edge on line 2: latency and vector.
        bus.irq_lines = 4'b0100;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            check_eq("latency_pending2", 32'(bus.pending[2]), 32'(k >= LAT + 1));
            check_eq("latency_irq",      32'(bus.irq),        32'(k >= LAT + 2));
        end
        check_eq("line2_id",  32'(bus.irq_id),     32'd2);
        check_eq("line2_vec", 32'(bus.irq_vector), 32'h0000_FF20);
        pulse_ack();
        check_eq("ack_irq",     32'(bus.irq),        32'd0);
        check_eq("ack_service", 32'(bus.in_service), 32'd1);
        check_eq("ack_pending", 32'(bus.pending),    32'h0);
        pulse_eoi();
        bus.irq_lines = '0;
        repeat (4) tick();

        // Simultaneous edges on lines 3 and 1: priority order.
        bus.irq_lines = 4'b1010;
        repeat (LAT + 2) tick();
        check_eq("prio_first_id",  32'(bus.irq_id),     32'd1);
        check_eq("prio_first_vec", 32'(bus.irq_vector), 32'h0000_FF10);
        pulse_ack();
        pulse_eoi();
        check_eq("prio_gap_irq", 32'(bus.irq), 32'd0);
        tick();
        check_eq("prio_second_irq", 32'(bus.irq),        32'd1);
        check_eq("prio_second_id",  32'(bus.irq_id),     32'd3);
        check_eq("prio_second_vec", 32'(bus.irq_vector), 32'h0000_FF30);
        pulse_ack();
        pulse_eoi();
        bus.irq_lines = '0;
        repeat (4) tick();

        // Masked source stays pending until unmasked.
        bus.mask_write = 1'b1;
        bus.mask_data  = 4'b1110;
        tick();
        bus.mask_write = 1'b0;
        bus.irq_lines  = 4'b0001;
        repeat (LAT + 3) tick();
        check_eq("masked_pending", 32'(bus.pending), 32'h1);
        check_eq("masked_irq",     32'(bus.irq),     32'd0);
        bus.mask_write = 1'b1;
        bus.mask_data  = 4'b1111;
        tick();
        bus.mask_write = 1'b0;
        tick();
        check_eq("unmask_irq", 32'(bus.irq),    32'd1);
        check_eq("unmask_id",  32'(bus.irq_id), 32'd0);
        pulse_ack();

        // New edge and spurious ack while in service.
        bus.irq_lines = '0;
        repeat (LAT + 1) tick();
        bus.irq_lines = 4'b0001;
        repeat (LAT + 2) tick();
        check_eq("svc_pending", 32'(bus.pending), 32'h1);
        check_eq("svc_irq",     32'(bus.irq),     32'd0);
        pulse_ack();
        check_eq("spurious_service", 32'(bus.in_service), 32'd1);
        check_eq("spurious_irq",     32'(bus.irq),        32'd0);
        check_eq("spurious_pending", 32'(bus.pending),    32'h1);
        pulse_eoi();
        tick();
        check_eq("post_eoi_irq", 32'(bus.irq), 32'd1);

        // Reset while in ASSERT.
        bus.mask_write = 1'b1;
        bus.mask_data  = 4'b0110;
        tick();
        bus.mask_write = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_assert_irq",     32'(bus.irq),     32'd0);
        check_eq("rst_assert_pending", 32'(bus.pending), 32'h0);
        check_eq("rst_assert_mask",    32'(bus.mask),    32'hF);
        bus.irq_lines = '0;
        repeat (4) tick();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) bus.irq_lines = 4'($urandom);
            bus.mask_write = ($urandom_range(0, 15) == 0);
            bus.mask_data  = 4'($urandom);
            bus.reset_irq  = ($urandom_range(0, 3) == 0);
            bus.eoi        = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Upstream interrupt source for the CPU control path.
- Captures rising edges on external interrupt lines and prioritises them by fixed priority.
- Drives the CPU `irq` request and the 16-bit handler vector that the control path loads into PC when it takes an interrupt.
- Completes the handshake on the control path's `reset_irq` pulse, then blocks further requests until end-of-interrupt (issued on RTI).

Parameters:
- NUM_SOURCES, 4, number of interrupt lines (2..8); index 0 is highest priority.
- VECTOR_BASE, 16'hFF00, handler address of source 0.
- VECTOR_STRIDE, 16'h0010, address spacing between consecutive source handlers.
- MASK_RESET, all ones, mask value loaded at reset (1 = enabled).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irq_lines  in  NUM_SOURCES  raw interrupt lines; rising edge = request.
- mask_write  in  1  load mask_data into mask register this cycle.
- mask_data  in  NUM_SOURCES  new mask value.
- reset_irq  in  1  acknowledge pulse from control path (interrupt taken).
- eoi  in  1  end-of-interrupt pulse (RTI retired).
- irq  out  1  interrupt request to control path.
- irq_vector  out  16  handler address for the latched source.
- irq_id  out  $clog2(NUM_SOURCES)  latched source index.
- pending  out  NUM_SOURCES  captured, not-yet-acknowledged requests.
- mask  out  NUM_SOURCES  current mask register.
- in_service  out  1  handler currently running.

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- Reset values:
  - state = IDLE; irq = 0, in_service = 0.
  - pending = 0, irq_id = 0, irq_vector = VECTOR_BASE.
  - mask = MASK_RESET.
  - Edge-detect and synchroniser flops = all ones, so a line held high through reset produces no event.
- Reset mid-handshake (any state) returns to IDLE and drops all pending events.
- Edge capture: pending[i] sets on a detected rising edge of line i, regardless of mask.
- Masking: a masked pending bit stays pending and becomes eligible when unmasked. mask_write takes effect next cycle.
- Selection: the lowest index i with pending[i] & mask[i].
- State machine (all outputs registered):
  - IDLE: if any eligible source exists, latch irq_id = selected index and irq_vector = VECTOR_BASE + irq_id*VECTOR_STRIDE (16-bit, wrap modulo 2^16); go to ASSERT. irq goes high the cycle after the edge that moves to ASSERT.
  - ASSERT: irq = 1; irq_id and irq_vector are frozen even if mask or pending change. On reset_irq: clear pending[irq_id], drop irq, set in_service, go to SERVICE.
  - SERVICE: irq = 0; new edges still accumulate into pending. On eoi: clear in_service, go to IDLE; the next eligible source may be latched no earlier than the following cycle.
- Simultaneous events:
  - New edge on irq_id in the same cycle as its clear: set wins (stays pending).
  - eoi in IDLE or ASSERT is ignored; reset_irq outside ASSERT is ignored.
  - mask_write and edge in the same cycle: both take effect.
- reset_irq and eoi are single-cycle pulses; a level held high acts once per state entry.

Optional Feature:
- Macro IRQC_SYNC_EN.
- Defined: each line passes through a 2-flop synchroniser before edge detection. pending is set after the 3rd rising clock edge at which the line is sampled high; irq rises one edge later.
- Undefined: edge detection runs directly on irq_lines. pending is set at the 1st edge sampling high; irq rises at the 2nd.
- All other behaviour is identical.

Test Plan:
- Reset, then a single edge on line 2 (macro off, defaults) -> irq = 1 at the 2nd edge, irq_id = 2, irq_vector = 16'hFF20; pulse reset_irq -> irq = 0, in_service = 1, pending = 4'b0000.
- Edges on lines 3 and 1 in the same cycle -> irq_id = 1 (vector 16'hFF10); after reset_irq + eoi -> irq_id = 3 (vector 16'hFF30), with at least one cycle with irq = 0 in between.
- mask = 4'b1110, edge on line 0 -> pending = 4'b0001, irq stays 0; write mask = 4'b1111 -> irq = 1 and irq_id = 0 two cycles after mask_write.
- In SERVICE, edge on line 0 -> pending[0] = 1 but irq = 0 until eoi; a spurious reset_irq in SERVICE changes nothing.
- Line 1 held high across reset -> no pending after reset; assert reset while in ASSERT -> next cycle irq = 0, pending = 0, mask = 4'b1111.
- Macro on: line 2 rises -> pending[2] = 1 after the 3rd edge and irq = 1 after the 4th; macro off: the 1st and 2nd edges respectively.
